// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-item vending controller with coin credit, cancel, timeout refund and coin-by-coin change.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   coin5, coin10       one-cycle coin insertion pulses (both together = 15)
//   sel_valid, sel_item item selection request and index
//   cancel              refund request
//   credit              current credit
//   vend_valid/item     one-cycle dispense strobe and dispensed item
//   sel_deny            selection refused (short credit or bad index)
//   coin_reject         inserted coin(s) returned unaccepted
//   chg5, chg10         eject one change coin
//   busy, state_o       VEND/CHANGE indicator and raw state encoding
module vend_ctrl_multi #(
    parameter int                         N_ITEMS     = 4,
    parameter int                         PRICE_W     = 8,
    parameter logic [PRICE_W*N_ITEMS-1:0] ITEM_PRICES = 32'h2D_28_19_0F,
    parameter int                         MAX_CREDIT  = 200,
    parameter int                         TIMEOUT     = 1000,
    parameter int                         SEL_W       = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               coin5,
    input  logic               coin10,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel_item,
    input  logic               cancel,
    output logic [PRICE_W-1:0] credit,
    output logic               vend_valid,
    output logic [SEL_W-1:0]   vend_item,
    output logic               sel_deny,
    output logic               coin_reject,
    output logic               chg5,
    output logic               chg10,
    output logic               busy,
    output logic [1:0]         state_o
);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [PRICE_W:0]   MAX_C    = (PRICE_W+1)'(MAX_CREDIT);
    localparam logic [PRICE_W-1:0] C5       = PRICE_W'(5);
    localparam logic [PRICE_W-1:0] C10      = PRICE_W'(10);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [PRICE_W-1:0] credit_q, credit_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [SEL_W-1:0]   item_q, item_d;
    logic vend_q, vend_d, deny_q, deny_d, rej_q, rej_d, c5_q, c5_d, c10_q, c10_d;

    logic [PRICE_W-1:0] price;
    logic [PRICE_W:0]   coin_val, sum;
    logic               item_ok, buy, coin_any, coin_ok;

    always_comb begin
        price = '0;
        for (int i = 0; i < N_ITEMS; i++)
            if (int'(sel_item) == i) price = ITEM_PRICES[PRICE_W*i +: PRICE_W];
    end

    assign item_ok  = int'(sel_item) < N_ITEMS;
    assign buy      = sel_valid && item_ok && credit_q >= price;
    assign coin_any = coin5 | coin10;
    assign coin_val = (PRICE_W+1)'(coin5 ? 5 : 0) + (PRICE_W+1)'(coin10 ? 10 : 0);
    // A coin arriving with a purchase is judged against the post-purchase credit.
    assign sum      = {1'b0, credit_q} - (buy ? {1'b0, price} : '0) + coin_val;
    assign coin_ok  = coin_any && sum <= MAX_C;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        tmr_d    = '0;
        item_d   = item_q;
        vend_d   = 1'b0;
        deny_d   = 1'b0;
        rej_d    = 1'b0;
        c5_d     = 1'b0;
        c10_d    = 1'b0;
        case (state_q)
            IDLE: begin
                deny_d = sel_valid;
                rej_d  = coin_any && !coin_ok;
                if (coin_ok) begin
                    credit_d = sum[PRICE_W-1:0];
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                // Cancel and timeout both refund; any coin in that cycle goes straight back.
                if (cancel || tmr_q == TMR_LAST) begin
                    state_d = CHANGE;
                    rej_d   = coin_any;
                end else begin
                    deny_d   = sel_valid && !buy;
                    rej_d    = coin_any && !coin_ok;
                    credit_d = coin_ok ? sum[PRICE_W-1:0] : credit_q - (buy ? price : '0);
                    tmr_d    = (coin_ok || sel_valid) ? '0 : tmr_q + 1'b1;
                    if (buy) begin
                        state_d = VEND;
                        item_d  = sel_item;
                        vend_d  = 1'b1;
                    end
                end
            end
            VEND: begin
                rej_d   = coin_any;
                state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_d    = coin_any;
                c10_d    = credit_q >= C10;
                c5_d     = credit_q < C10 && credit_q >= C5;
                credit_d = c10_d ? credit_q - C10 : c5_d ? credit_q - C5 : '0;
                state_d  = (credit_d == '0) ? IDLE : CHANGE;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            tmr_q    <= '0;
            item_q   <= '0;
            vend_q   <= 1'b0;
            deny_q   <= 1'b0;
            rej_q    <= 1'b0;
            c5_q     <= 1'b0;
            c10_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            tmr_q    <= tmr_d;
            item_q   <= item_d;
            vend_q   <= vend_d;
            deny_q   <= deny_d;
            rej_q    <= rej_d;
            c5_q     <= c5_d;
            c10_q    <= c10_d;
        end
    end

    assign credit      = credit_q;
    assign vend_valid  = vend_q;
    assign vend_item   = item_q;
    assign sel_deny    = deny_q;
    assign coin_reject = rej_q;
    assign chg5        = c5_q;
    assign chg10       = c10_q;
    assign busy        = state_q == VEND || state_q == CHANGE;
    assign state_o     = state_q;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed self-checking bench for vend_ctrl_multi (default build plus a small-credit, 3-item build).
module tb_vend_ctrl_multi;
    logic       clk = 1'b0, reset_n = 1'b0;
    logic       coin5 = 1'b0, coin10 = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
    logic [1:0] sel_item = 2'd0;

    logic [7:0] a_cr, b_cr;
    logic [1:0] a_vi, b_vi, a_st, b_st;
    logic a_vv, a_dn, a_rj, a_c5, a_c10, a_bz;
    logic b_vv, b_dn, b_rj, b_c5, b_c10, b_bz;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    vend_ctrl_multi u_a (
        .clk(clk), .reset_n(reset_n), .coin5(coin5), .coin10(coin10),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .credit(a_cr), .vend_valid(a_vv), .vend_item(a_vi), .sel_deny(a_dn),
        .coin_reject(a_rj), .chg5(a_c5), .chg10(a_c10), .busy(a_bz), .state_o(a_st)
    );

    vend_ctrl_multi #(
        .N_ITEMS(3), .PRICE_W(8), .ITEM_PRICES(24'h28_19_0F),
        .MAX_CREDIT(20), .TIMEOUT(8), .SEL_W(2)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .coin5(coin5), .coin10(coin10),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .credit(b_cr), .vend_valid(b_vv), .vend_item(b_vi), .sel_deny(b_dn),
        .coin_reject(b_rj), .chg5(b_c5), .chg10(b_c10), .busy(b_bz), .state_o(b_st)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c5, input logic c10, input logic sv, input logic [1:0] si, input logic cn);
        coin5 = c5; coin10 = c10; sel_valid = sv; sel_item = si; cancel = cn;
        @(posedge clk);
        #1;
        coin5 = 1'b0; coin10 = 1'b0; sel_valid = 1'b0; sel_item = 2'd0; cancel = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk8("rst_state", {6'd0, a_st}, 8'd0);
        chk8("rst_credit", a_cr, 8'd0);
        chk1("rst_vend", a_vv, 1'b0);
        chk1("rst_busy", a_bz, 1'b0);
        chk1("rst_chg10", a_c10, 1'b0);
        chk1("rst_reject", a_rj, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 4 x coin10, buy item2 (40): exact credit, no change
        step(0, 1, 0, 0, 0);
        chk8("t1_credit10", a_cr, 8'd10);
        chk8("t1_collect", {6'd0, a_st}, 8'd1);
        repeat (3) step(0, 1, 0, 0, 0);
        chk8("t1_credit40", a_cr, 8'd40);
        step(0, 0, 1, 2, 0);
        chk1("t1_vend", a_vv, 1'b1);
        chk8("t1_item", {6'd0, a_vi}, 8'd2);
        chk8("t1_credit0", a_cr, 8'd0);
        chk1("t1_busy", a_bz, 1'b1);
        step(0, 0, 0, 0, 0);
        chk8("t1_idle", {6'd0, a_st}, 8'd0);
        chk1("t1_no_chg5", a_c5, 1'b0);
        chk1("t1_no_chg10", a_c10, 1'b0);
        chk1("t1_vend_off", a_vv, 1'b0);

        // 5 x coin10 (50), buy item3 (45): one chg5
        repeat (5) step(0, 1, 0, 0, 0);
        chk8("t2_credit50", a_cr, 8'd50);
        step(0, 0, 1, 3, 0);
        chk1("t2_vend", a_vv, 1'b1);
        chk8("t2_item", {6'd0, a_vi}, 8'd3);
        chk8("t2_credit5", a_cr, 8'd5);
        step(0, 0, 0, 0, 0);
        chk8("t2_change", {6'd0, a_st}, 8'd3);
        chk1("t2_no_chg_yet", a_c5, 1'b0);
        step(0, 0, 0, 0, 0);
        chk1("t2_chg5", a_c5, 1'b1);
        chk1("t2_no_chg10", a_c10, 1'b0);
        chk8("t2_credit0", a_cr, 8'd0);
        chk8("t2_idle", {6'd0, a_st}, 8'd0);
        step(0, 0, 0, 0, 0);
        chk1("t2_chg5_once", a_c5, 1'b0);

        // insufficient credit then top-up and buy item0 (15)
        step(1, 0, 0, 0, 0);
        chk8("t3_credit5", a_cr, 8'd5);
        step(0, 0, 1, 0, 0);
        chk1("t3_deny", a_dn, 1'b1);
        chk8("t3_stay", {6'd0, a_st}, 8'd1);
        chk8("t3_credit_kept", a_cr, 8'd5);
        chk1("t3_no_vend", a_vv, 1'b0);
        step(0, 1, 0, 0, 0);
        chk8("t3_credit15", a_cr, 8'd15);
        chk1("t3_deny_off", a_dn, 1'b0);
        step(0, 0, 1, 0, 0);
        chk1("t3_vend", a_vv, 1'b1);
        chk8("t3_item", {6'd0, a_vi}, 8'd0);
        chk8("t3_credit0", a_cr, 8'd0);
        step(0, 0, 0, 0, 0);
        chk8("t3_idle", {6'd0, a_st}, 8'd0);

        // credit 35, cancel with coin5: reject, then 10,10,10,5
        repeat (3) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk8("t4_credit35", a_cr, 8'd35);
        step(1, 0, 0, 0, 1);
        chk1("t4_reject", a_rj, 1'b1);
        chk8("t4_change", {6'd0, a_st}, 8'd3);
        chk8("t4_credit_kept", a_cr, 8'd35);
        step(0, 0, 0, 0, 0);
        chk1("t4_c10_a", a_c10, 1'b1);
        chk8("t4_cr25", a_cr, 8'd25);
        chk1("t4_reject_off", a_rj, 1'b0);
        step(0, 0, 0, 0, 0);
        chk1("t4_c10_b", a_c10, 1'b1);
        chk8("t4_cr15", a_cr, 8'd15);
        step(0, 0, 0, 0, 0);
        chk1("t4_c10_c", a_c10, 1'b1);
        chk8("t4_cr5", a_cr, 8'd5);
        step(0, 0, 0, 0, 0);
        chk1("t4_c5", a_c5, 1'b1);
        chk1("t4_c10_off", a_c10, 1'b0);
        chk8("t4_cr0", a_cr, 8'd0);
        chk8("t4_idle", {6'd0, a_st}, 8'd0);
        step(0, 0, 0, 0, 0);
        chk1("t4_c5_off", a_c5, 1'b0);

        // small build: MAX_CREDIT 20, bad index, over-credit, timeout refund
        do_reset();
        chk8("t5_rst_credit", b_cr, 8'd0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk8("t5_credit20", b_cr, 8'd20);
        step(0, 0, 1, 3, 0);
        chk1("t5_bad_index_deny", b_dn, 1'b1);
        chk1("t5_bad_index_no_vend", b_vv, 1'b0);
        chk8("t5_bad_index_credit", b_cr, 8'd20);
        step(1, 1, 0, 0, 0);
        chk1("t5_over_reject", b_rj, 1'b1);
        chk8("t5_over_credit", b_cr, 8'd20);
        chk8("t5_over_stay", {6'd0, b_st}, 8'd1);
        repeat (6) step(0, 0, 0, 0, 0);
        chk8("t5_pre_timeout", {6'd0, b_st}, 8'd1);
        step(0, 0, 0, 0, 0);
        chk8("t5_timeout", {6'd0, b_st}, 8'd3);
        chk1("t5_timeout_no_pulse", b_c10, 1'b0);
        step(0, 0, 0, 0, 0);
        chk1("t5_c10_a", b_c10, 1'b1);
        chk8("t5_cr10", b_cr, 8'd10);
        step(0, 0, 0, 0, 0);
        chk1("t5_c10_b", b_c10, 1'b1);
        chk8("t5_cr0", b_cr, 8'd0);
        chk8("t5_idle", {6'd0, b_st}, 8'd0);

        // coin during CHANGE, then reset mid-change
        do_reset();
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk8("t6_change", {6'd0, a_st}, 8'd3);
        step(1, 0, 0, 0, 0);
        chk1("t6_busy_reject", a_rj, 1'b1);
        chk1("t6_c10", a_c10, 1'b1);
        chk8("t6_cr10", a_cr, 8'd10);
        reset_n = 1'b0;
        #1;
        chk8("t6_rst_state", {6'd0, a_st}, 8'd0);
        chk8("t6_rst_credit", a_cr, 8'd0);
        chk1("t6_rst_c10", a_c10, 1'b0);
        chk1("t6_rst_reject", a_rj, 1'b0);
        chk1("t6_rst_busy", a_bz, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk1("t6_post_c10", a_c10, 1'b0);
            chk1("t6_post_c5", a_c5, 1'b0);
            chk8("t6_post_state", {6'd0, a_st}, 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
